// File: rtl/vol_display_scan_ctrl.sv
// Purpose: scans a 4-digit common-anode 7-seg display showing volume level and a direction glyph.
// Latency: events change state/busy one cycle later; each digit slot is one dead cycle then REFRESH_DIV-1 lit cycles.
// Backpressure: none; event pulses are always accepted, simultaneous up/down pulses are dropped.
module vol_display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_TICKS  = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_evt,
  input  logic       dn_evt,
  input  logic [3:0] level,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] P_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] H_LOAD = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  // Active-high {a..g} glyphs for the indicator digit
  localparam logic [6:0] GLYPH_UP = 7'b1100011;
  localparam logic [6:0] GLYPH_DN = 7'b0011101;

  typedef enum logic [1:0] {IDLE, SHOW_UP, SHOW_DN} state_t;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;   // slot that the next tick will open
  logic [1:0]    r_slot;    // slot opened by the most recent tick
  logic          r_load;    // dead cycle in progress, light r_slot on next edge
  logic [3:0]    r_lvl;
  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_busy;

  logic          w_tick;
  logic          w_up_only;
  logic          w_dn_only;
  logic [3:0]    w_units;
  logic          w_tens;
  logic [6:0]    w_pat;

  assign w_tick    = (r_presc == P_MAX);
  assign w_up_only = up_evt & ~dn_evt;
  assign w_dn_only = dn_evt & ~up_evt;

  assign seg  = r_seg;
  assign an   = r_an;
  assign busy = r_busy;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Active-high content of the slot about to be lit, from the frame-latched level and current glyph state
  always_comb begin
    w_tens  = (r_lvl >= 4'd10);
    w_units = w_tens ? (r_lvl - 4'd10) : r_lvl;
    w_pat   = 7'b0000000;
    case (r_slot)
      2'd0: w_pat = dec7(w_units);
      2'd1: w_pat = w_tens ? dec7(4'd1) : 7'b0000000;
      2'd2: w_pat = 7'b0000000;
      2'd3: begin
        if (r_state == SHOW_UP)      w_pat = GLYPH_UP;
        else if (r_state == SHOW_DN) w_pat = GLYPH_DN;
        else                         w_pat = 7'b0000000;
      end
      default: w_pat = 7'b0000000;
    endcase
  end

  // Prescaler, digit walk, dead cycle and per-frame level latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_digit <= 2'd0;
      r_slot  <= 2'd0;
      r_load  <= 1'b0;
      r_lvl   <= 4'd0;
      r_an    <= 4'b1111;
      r_seg   <= 7'b1111111;
    end else begin
      r_presc <= w_tick ? '0 : (r_presc + 1'b1);
      if (w_tick) begin
        // Blank everything for one cycle so the old pattern never ghosts onto the new anode
        r_an    <= 4'b1111;
        r_seg   <= 7'b1111111;
        r_slot  <= r_digit;
        r_digit <= r_digit + 2'd1;
        r_load  <= 1'b1;
        // Latch the level only when the last slot of the frame opens, so a frame never mixes two levels
        if (r_digit == 2'd3) begin
          r_lvl <= level;
        end
      end else if (r_load) begin
        r_an   <= ~(4'b0001 << r_slot);
        r_seg  <= ~w_pat;
        r_load <= 1'b0;
      end
    end
  end

  // Indicator FSM with hold counter; busy is registered next to the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_busy  <= 1'b0;
    end else if (w_up_only) begin
      r_state <= SHOW_UP;
      r_hold  <= H_LOAD;
      r_busy  <= 1'b1;
    end else if (w_dn_only) begin
      r_state <= SHOW_DN;
      r_hold  <= H_LOAD;
      r_busy  <= 1'b1;
    end else if (w_tick && (r_state != IDLE)) begin
      if (r_hold <= H_ONE) begin
        r_state <= IDLE;
        r_hold  <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_hold <= r_hold - H_ONE;
      end
    end
  end

endmodule

// File: tb/tb_vol_display_scan_ctrl.sv
// Bench for vol_display_scan_ctrl: directed scenarios plus random traffic against a cycle model.
// Model tracks time as edges since reset and the glyph as "ticks remaining" with a direction.
// Every cycle compares an/seg/busy; a few literal values pin the model.
module tb_vol_display_scan_ctrl;

  localparam int DIV  = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_evt = 1'b0;
  logic       dn_evt = 1'b0;
  logic [3:0] level = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int checks = 0;
  int failures = 0;

  vol_display_scan_ctrl #(.REFRESH_DIV(DIV), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .rst(rst), .up_evt(up_evt), .dn_evt(dn_evt),
    .level(level), .seg(seg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_n;      // non-reset edges since reset
  int         m_tk;     // ticks since reset
  int         m_rem;    // ticks the glyph remains lit
  logic       m_up;     // direction of the last accepted event
  logic       m_pend;
  int         m_slot;
  logic [3:0] m_lvl;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_busy;
  logic [6:0] dec [0:9];

  function automatic logic [6:0] content(input int slot);
    logic [6:0] p;
    p = 7'b0000000;
    if (slot == 0) p = dec[int'(m_lvl) % 10];
    else if (slot == 1) p = (m_lvl >= 4'd10) ? dec[1] : 7'b0000000;
    else if (slot == 3 && m_rem > 0) p = m_up ? 7'b1100011 : 7'b0011101;
    return p;
  endfunction

  task automatic model_edge();
    logic [3:0] one;
    bit tick;
    one = 4'b0001;
    if (rst) begin
      m_n = 0; m_tk = 0; m_rem = 0; m_up = 1'b0; m_pend = 1'b0; m_slot = 0;
      m_lvl = 4'd0; m_an = 4'b1111; m_seg = 7'b1111111;
    end else begin
      tick = ((m_n % DIV) == DIV - 1);
      if (m_pend) begin
        m_an   = ~(one << m_slot);
        m_seg  = ~content(m_slot);
        m_pend = 1'b0;
      end
      if (tick) begin
        m_an   = 4'b1111;
        m_seg  = 7'b1111111;
        m_slot = m_tk % 4;
        m_pend = 1'b1;
        if (m_slot == 3) m_lvl = level;
        m_tk++;
      end
      if (up_evt != dn_evt) begin
        m_rem = HOLD;
        m_up  = up_evt;
      end else if (tick && m_rem > 0) begin
        m_rem--;
      end
      m_n++;
    end
    m_busy = (m_rem > 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model absorbs the inputs seen at the edge, then DUT is compared
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("an", {28'd0, an}, {28'd0, m_an});
    check("seg", {25'd0, seg}, {25'd0, m_seg});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int k;
    k = 0;
    while (an !== target && k < 200) begin
      step();
      k++;
    end
    check(name, {28'd0, an}, {28'd0, target});
  endtask

  task automatic pulse(input logic u, input logic d);
    up_evt = u;
    dn_evt = d;
    step();
    up_evt = 1'b0;
    dn_evt = 1'b0;
  endtask

  initial begin
    dec[0] = 7'b1111110; dec[1] = 7'b0110000; dec[2] = 7'b1101101; dec[3] = 7'b1111001;
    dec[4] = 7'b0110011; dec[5] = 7'b1011011; dec[6] = 7'b1011111; dec[7] = 7'b1110000;
    dec[8] = 7'b1111111; dec[9] = 7'b1111011;

    // Reset and scan walk with level 7
    rst = 1'b1;
    step();
    step();
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    level = 4'd7;
    run(3);
    check("pre_tick_an", {28'd0, an}, 32'hF);
    run(40);
    wait_an(4'b1110, "wait_d0_l7");
    check("l7_d0", {25'd0, seg}, {25'd0, 7'b0001111});

    // Two-digit level, then a mid-frame change that must wait for the wrap
    level = 4'd13;
    run(40);
    wait_an(4'b1101, "wait_d1_l13");
    check("l13_d1", {25'd0, seg}, {25'd0, 7'b1001111});
    wait_an(4'b1110, "wait_d0_l13");
    check("l13_d0", {25'd0, seg}, {25'd0, 7'b0000110});
    level = 4'd5;
    wait_an(4'b1101, "wait_d1_hold");
    check("l13_d1_kept", {25'd0, seg}, {25'd0, 7'b1001111});
    wait_an(4'b1110, "wait_d0_l5");
    check("l5_d0", {25'd0, seg}, {25'd0, 7'b0100100});

    // Up event and hold expiry
    pulse(1'b1, 1'b0);
    check("up_busy", {31'd0, busy}, 32'd1);
    wait_an(4'b0111, "wait_d3_up");
    check("up_glyph", {25'd0, seg}, {25'd0, 7'b0011100});
    run(HOLD * DIV + 20);
    check("up_expired", {31'd0, busy}, 32'd0);

    // Retrigger with a switch of direction
    pulse(1'b1, 1'b0);
    run(5 * DIV);
    pulse(1'b0, 1'b1);
    wait_an(4'b1110, "wait_d0_dn");
    wait_an(4'b0111, "wait_d3_dn");
    check("dn_glyph", {25'd0, seg}, {25'd0, 7'b1100010});
    run(HOLD * DIV + 20);

    // Simultaneous events: ignored in IDLE and mid-hold
    pulse(1'b1, 1'b1);
    check("both_idle", {31'd0, busy}, 32'd0);
    pulse(1'b1, 1'b0);
    run(5 * DIV);
    pulse(1'b1, 1'b1);
    run(HOLD * DIV);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      up_evt = (r < 3) || (r == 6);
      dn_evt = (r >= 3 && r < 7);
      if ($urandom_range(0, 19) == 0) level = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    up_evt = 1'b0;
    dn_evt = 1'b0;
    run(10);

    // Reset in the middle of a down hold while digit2 is lit
    pulse(1'b0, 1'b1);
    wait_an(4'b1011, "wait_d2_rst");
    rst = 1'b1;
    step();
    check("mid_rst_an", {28'd0, an}, 32'hF);
    check("mid_rst_seg", {25'd0, seg}, 32'h7F);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    run(DIV + 1);
    check("restart_d0", {28'd0, an}, {28'd0, 4'b1110});
    run(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
